alien_line_scheduler: RTL
=========================

ALIEN_LINE_SCHEDULER -- requirements
Module: alien_line_scheduler

Interface
REQ-001 The block SHALL have parameter N_SLOTS, default 8, meaning the number of alien table slots (index width SW = $clog2(N_SLOTS)).
REQ-002 The block SHALL have parameter N_LINE, default 4, meaning the maximum number of aliens scheduled on one scanline.
REQ-003 The block SHALL have parameter H_ACTIVE, default 640, meaning the first h_cnt value of horizontal blanking.
REQ-004 The block SHALL have parameter V_ACTIVE, default 480, meaning the first v_cnt value of vertical blanking.
REQ-005 The block SHALL have parameter V_TOTAL, default 525, meaning the number of lines per frame.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be synchronous to its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have ports h_cnt and v_cnt, input, 10 bits each: current VGA pixel position, sampled every clk.
REQ-009 The block SHALL have ports wr_en (1), wr_idx (SW) and wr_data (AlienData): write one slot of the pending table.
REQ-010 The block SHALL have port wr_kill, input, 1 bit: with wr_en, marks slot wr_idx invalid instead of writing it.
REQ-011 The block SHALL have port tbl_clear, input, 1 bit: invalidates every pending slot.
REQ-012 The block SHALL have outputs obj_data (AlienData), obj_hit (1) and obj_slot (SW): the alien selected for the current pixel, feeding the renderer.
REQ-013 The block SHALL have outputs line_overflow (1, sticky per frame) and scan_busy (1).

Function
REQ-014 The table SHALL be double-buffered: writes affect the pending table only; the active table is loaded from pending on the vblank event, i.e. the first clk where v_cnt==V_ACTIVE and h_cnt==0, detected by comparison with the previous cycle's registered value so it fires once.
REQ-015 On a write in the same cycle as the vblank load, the active table SHALL receive the pre-write pending contents; the write SHALL land in pending only.
REQ-016 When tbl_clear and wr_en coincide, slot wr_idx SHALL take the write (or kill); all other slots SHALL be invalidated.
REQ-017 The scan FSM SHALL have states IDLE, SCAN, DONE; IDLE to SCAN on the hblank event (first clk with h_cnt==H_ACTIVE, edge-detected).
REQ-018 On entry to SCAN, target line L SHALL be v_cnt+1, wrapping to 0 when v_cnt==V_TOTAL-1.
REQ-019 SCAN SHALL evaluate one active slot per clk in ascending index, taking exactly N_SLOTS cycles, then move to DONE.
REQ-020 A slot SHALL hit when it is valid, hh = 32 - _r is greater than 0, and (_y_pos - hh) <= L < (_y_pos + hh), all computed in 12-bit signed arithmetic so that top-edge underflow clips correctly.
REQ-021 Hits SHALL be appended to the next-line list in slot order; a hit found when the list already holds N_LINE entries SHALL be dropped and SHALL set line_overflow.
REQ-022 DONE SHALL wait for h_cnt==0 (edge-detected), then copy the next-line list into the current-line list, clear the next-line list, and return to IDLE.
REQ-023 scan_busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-024 A hblank event arriving outside IDLE SHALL be ignored.
REQ-025 Per pixel, the block SHALL select the lowest-position current-line entry with (_x_pos - hh) <= h_cnt < (_x_pos + hh), again in signed arithmetic.
REQ-026 The selection result SHALL be registered with exactly 1 clk latency: obj_hit, obj_slot and obj_data reflect the h_cnt/v_cnt of the previous cycle.
REQ-027 With no match, or v_cnt >= V_ACTIVE, the block SHALL drive obj_hit=0, obj_slot=0 and obj_data all zero.
REQ-028 line_overflow SHALL clear on the vblank event unless an overflow occurs in the same cycle, in which case overflow wins.

Reset
REQ-029 rst SHALL invalidate every pending and active slot and empty both line lists.
REQ-030 rst SHALL force the FSM to IDLE and drive obj_hit, obj_slot, obj_data, line_overflow and scan_busy to 0.
REQ-031 rst asserted during SCAN SHALL abort the scan, and no partial list SHALL ever be promoted.
REQ-032 The edge detectors SHALL reset so that no event fires on the first cycle after reset.

Verification
REQ-033 Write slot 2 with x=100, y=200, r=16; run a vblank, then line 199 -> obj_hit=1, obj_slot=2 one clk after each h_cnt in 84..115, and 0 elsewhere.
REQ-034 Place 6 valid aliens all spanning line 50 -> only slots 0..3 are scheduled, line_overflow=1, and it clears at the next vblank.
REQ-035 Make slots 1 and 3 overlap at h_cnt=300 -> obj_slot=1.
REQ-036 Use y=10, r=0 (hh=32) -> hits on lines 0..41 with no wrap artefact on line 524; the scan at v_cnt=524 targets L=0.
REQ-037 Write during the vblank-load cycle, then on the next frame -> the new data is invisible until the following vblank.
REQ-038 Assert rst at SCAN cycle 3 -> the FSM returns to IDLE, all outputs are 0, and the next line shows no hits.

Source files
------------

// File: rtl/alien_line_scheduler.sv
// -----------------------------------------------------------------------------
// alien_pkg / alien_line_scheduler
//
// Purpose: per-scanline sprite scheduler for a VGA alien renderer. A pending
// alien table is written by the game logic and copied into the active table
// once per frame at the start of vertical blanking. During each horizontal
// blanking interval the active table is scanned, one slot per clock, to
// build the list of at most N_LINE aliens that cover the next line. For every
// pixel of a line, the lowest-position list entry covering h_cnt is presented
// to the renderer one clock later.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   h_cnt, v_cnt     : current VGA pixel position (10 bits each)
//   wr_en, wr_idx,
//   wr_data, wr_kill : write (or, with wr_kill, invalidate) one pending slot
//   tbl_clear        : invalidate every pending slot (a coincident write wins
//                      for its own slot)
//   obj_data, obj_hit,
//   obj_slot         : alien selected for the previous cycle's pixel
//   line_overflow    : a line held more than N_LINE aliens (sticky per frame)
//   scan_busy        : the line scan is running or waiting for the next line
// -----------------------------------------------------------------------------
package alien_pkg;
    typedef struct packed {
        logic [9:0] _x_pos;
        logic [9:0] _y_pos;
        logic [5:0] _r;
    } AlienData;
endpackage

module alien_line_scheduler
    import alien_pkg::*;
#(
    parameter int N_SLOTS  = 8,
    parameter int N_LINE   = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    localparam int SW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    h_cnt,
    input  logic [9:0]    v_cnt,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_idx,
    input  AlienData      wr_data,
    input  logic          wr_kill,
    input  logic          tbl_clear,
    output AlienData      obj_data,
    output logic          obj_hit,
    output logic [SW-1:0] obj_slot,
    output logic          line_overflow,
    output logic          scan_busy
);

    localparam int CW = $clog2(N_LINE + 1);
    localparam int LW = (N_LINE > 1) ? $clog2(N_LINE) : 1;
    localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // A span of half-height hh = 32 - r around ctr covers pos when hh > 0 and
    // ctr - hh <= pos < ctr + hh. Signed 12-bit math lets ctr - hh go negative
    // so aliens near the top/left edge clip instead of wrapping.
    function automatic logic span_hit(input logic [9:0] pos, input logic [9:0] ctr,
                                      input logic [5:0] r);
        logic signed [11:0] hh;
        logic signed [11:0] c;
        logic signed [11:0] p;
        hh = 12'sd32 - $signed({6'd0, r});
        c  = $signed({2'd0, ctr});
        p  = $signed({2'd0, pos});
        return (hh > 12'sd0) && ((c - hh) <= p) && (p < (c + hh));
    endfunction

    AlienData         pend_data_q [N_SLOTS];
    AlienData         pend_data_d [N_SLOTS];
    AlienData         act_data_q  [N_SLOTS];
    AlienData         act_data_d  [N_SLOTS];
    logic [N_SLOTS-1:0] pend_vld_q, pend_vld_d;
    logic [N_SLOTS-1:0] act_vld_q, act_vld_d;

    state_t           state_q, state_d;
    logic [SW-1:0]    scan_idx_q, scan_idx_d;
    logic [9:0]       line_q, line_d;
    logic [CW-1:0]    nxt_cnt_q, nxt_cnt_d;
    logic [CW-1:0]    cur_cnt_q, cur_cnt_d;
    logic [SW-1:0]    nxt_slot_q [N_LINE];
    logic [SW-1:0]    nxt_slot_d [N_LINE];
    logic [SW-1:0]    cur_slot_q [N_LINE];
    logic [SW-1:0]    cur_slot_d [N_LINE];
    logic             ovf_q, ovf_d;

    logic             vb_prev_q, hb_prev_q, h0_prev_q;
    logic             vb_cond, hb_cond, h0_cond;
    logic             vb_ev, hb_ev, h0_ev;

    logic             obj_hit_q, obj_hit_d;
    logic [SW-1:0]    obj_slot_q, obj_slot_d;
    AlienData         obj_data_q, obj_data_d;

    logic             promote;
    logic [CW-1:0]    eff_cnt;
    logic [SW-1:0]    eff_slot [N_LINE];

    always_comb begin
        vb_cond = (v_cnt == V_ACT_C) && (h_cnt == 10'd0);
        hb_cond = (h_cnt == H_ACT_C);
        h0_cond = (h_cnt == 10'd0);
        vb_ev   = vb_cond && !vb_prev_q;
        hb_ev   = hb_cond && !hb_prev_q;
        h0_ev   = h0_cond && !h0_prev_q;

        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        act_data_d  = act_data_q;
        act_vld_d   = act_vld_q;
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        line_d      = line_q;
        nxt_cnt_d   = nxt_cnt_q;
        nxt_slot_d  = nxt_slot_q;
        cur_cnt_d   = cur_cnt_q;
        cur_slot_d  = cur_slot_q;
        ovf_d       = ovf_q;
        promote     = 1'b0;

        // The active copy takes the registered pending table, so a write in
        // the load cycle only reaches pending.
        if (vb_ev) begin
            act_data_d = pend_data_q;
            act_vld_d  = pend_vld_q;
            ovf_d      = 1'b0;
        end

        if (tbl_clear) begin
            pend_vld_d = '0;
        end
        if (wr_en) begin
            pend_vld_d[wr_idx] = !wr_kill;
            if (!wr_kill) begin
                pend_data_d[wr_idx] = wr_data;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (hb_ev) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                    line_d     = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end
            end
            SCAN: begin
                if (act_vld_q[scan_idx_q] &&
                    span_hit(line_q, act_data_q[scan_idx_q]._y_pos, act_data_q[scan_idx_q]._r)) begin
                    if (nxt_cnt_q == CW'(N_LINE)) begin
                        ovf_d = 1'b1;
                    end else begin
                        nxt_slot_d[nxt_cnt_q[LW-1:0]] = scan_idx_q;
                        nxt_cnt_d = nxt_cnt_q + CW'(1);
                    end
                end
                if (scan_idx_q == SW'(N_SLOTS - 1)) begin
                    state_d = DONE;
                end else begin
                    scan_idx_d = scan_idx_q + SW'(1);
                end
            end
            DONE: begin
                if (h0_ev) begin
                    promote    = 1'b1;
                    cur_cnt_d  = nxt_cnt_q;
                    cur_slot_d = nxt_slot_q;
                    nxt_cnt_d  = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The list being promoted this cycle already serves pixel h_cnt==0.
        eff_cnt  = promote ? nxt_cnt_q  : cur_cnt_q;
        eff_slot = promote ? nxt_slot_q : cur_slot_q;

        // Walk from the back so the lowest list position wins.
        obj_hit_d  = 1'b0;
        obj_slot_d = '0;
        obj_data_d = '0;
        for (int k = N_LINE - 1; k >= 0; k--) begin
            if ((CW'(k) < eff_cnt) &&
                span_hit(h_cnt, act_data_q[eff_slot[k]]._x_pos, act_data_q[eff_slot[k]]._r)) begin
                obj_hit_d  = 1'b1;
                obj_slot_d = eff_slot[k];
                obj_data_d = act_data_q[eff_slot[k]];
            end
        end
        if (v_cnt >= V_ACT_C) begin
            obj_hit_d  = 1'b0;
            obj_slot_d = '0;
            obj_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= '0;
            act_vld_q  <= '0;
            state_q    <= IDLE;
            scan_idx_q <= '0;
            line_q     <= '0;
            nxt_cnt_q  <= '0;
            cur_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            // Primed high so a condition already true out of reset is not an edge.
            vb_prev_q  <= 1'b1;
            hb_prev_q  <= 1'b1;
            h0_prev_q  <= 1'b1;
            obj_hit_q  <= 1'b0;
            obj_slot_q <= '0;
            obj_data_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            act_vld_q  <= act_vld_d;
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            line_q     <= line_d;
            nxt_cnt_q  <= nxt_cnt_d;
            cur_cnt_q  <= cur_cnt_d;
            ovf_q      <= ovf_d;
            vb_prev_q  <= vb_cond;
            hb_prev_q  <= hb_cond;
            h0_prev_q  <= h0_cond;
            obj_hit_q  <= obj_hit_d;
            obj_slot_q <= obj_slot_d;
            obj_data_q <= obj_data_d;
        end
    end

    // Table contents and list slot numbers are qualified by the valid bits and
    // counts above, so they carry no reset.
    always_ff @(posedge clk) begin
        pend_data_q <= pend_data_d;
        act_data_q  <= act_data_d;
        nxt_slot_q  <= nxt_slot_d;
        cur_slot_q  <= cur_slot_d;
    end

    assign obj_hit       = obj_hit_q;
    assign obj_slot      = obj_slot_q;
    assign obj_data      = obj_data_q;
    assign line_overflow = ovf_q;
    assign scan_busy     = (state_q != IDLE);

endmodule
